riscv_kernel_sequencer: RTL and testbench

// Host-side sequencer for the 5-stage RISC-V kernel. Owns the kernel's imem/dmem ports:

---
 rtl/riscv_kernel_sequencer_pkg.sv | 23 ++
 rtl/riscv_kernel_sequencer_rd_stage.sv | 50 +++++
 rtl/riscv_kernel_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_riscv_kernel_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_kernel_sequencer_pkg.sv
// Shared state encoding and counter sizing for the RISC-V kernel host sequencer.
package riscv_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CLEAR,
      RUN,
      DRAIN
   } seq_state_e;

   // Width able to count 0..max(a,b,c)-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/riscv_kernel_sequencer_rd_stage.sv
// Single-entry dmem read stage: issues a read, captures the 1-cycle-latency
// result and holds it on a valid/ready output until the consumer accepts it.
module seq_rd_stage #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue,
   input  logic [DW-1:0] dmem_q,
   input  logic          rd_ready,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          idle,
   output logic          fire
);

   logic          pend_q, pend_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      pend_d  = issue;
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && rd_ready) valid_d = 1'b0;
      // A pending read always follows a handshake, so the slot is free to refill.
      if (pend_q) begin
         valid_d = 1'b1;
         data_d  = dmem_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign rd_valid = valid_q;
   assign rd_data  = data_q;
   assign idle     = !pend_q && !valid_q;
   assign fire     = valid_q && rd_ready;

endmodule

// File: rtl/riscv_kernel_sequencer.sv
// Host-side sequencer for the 5-stage RISC-V kernel: loads imem, clears dmem,
// runs the core and streams dmem back, muxing the BRAM ports with the core.
module riscv_kernel_sequencer
   import riscv_seq_pkg::*;
#(
   parameter int IMEM_AW    = 6,
   parameter int DMEM_AW    = 5,
   parameter int DW         = 32,
   parameter int IMEM_WORDS = 40,
   parameter int DMEM_WORDS = 32,
   parameter int TIMEOUT    = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_go,
   input  logic               prog_valid,
   output logic               prog_ready,
   input  logic [DW-1:0]      prog_data,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [DW-1:0]      rd_data,
   output logic               busy,
   output logic               job_done,
   output logic               timeout_err,
   output logic               core_start,
   input  logic               core_done,
   input  logic [IMEM_AW-1:0] core_imem_addr,
   input  logic [DMEM_AW-1:0] core_dmem_addr,
   input  logic               core_dmem_we,
   input  logic [DW-1:0]      core_dmem_d,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic               imem_we,
   output logic [DW-1:0]      imem_d,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic               dmem_we,
   output logic [DW-1:0]      dmem_d,
   input  logic [DW-1:0]      dmem_q
);

   localparam int unsigned CW = cnt_width(IMEM_WORDS, DMEM_WORDS, TIMEOUT);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          prog_ready_q, prog_ready_d;
   logic          busy_q, busy_d;
   logic          core_start_q, core_start_d;
   logic          job_done_q, job_done_d;
   logic          timeout_q, timeout_d;

   logic               seq_imem_we;
   logic               seq_dmem_we;
   logic [DMEM_AW-1:0] seq_dmem_addr;
   logic               rd_issue;
   logic               rd_idle;
   logic               rd_fire;
   logic               run;

   seq_rd_stage #(.DW(DW)) u_rd_stage (
      .clk      (clk),
      .rst      (rst),
      .issue    (rd_issue),
      .dmem_q   (dmem_q),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .idle     (rd_idle),
      .fire     (rd_fire)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      timeout_d     = timeout_q;
      job_done_d    = 1'b0;
      seq_imem_we   = 1'b0;
      seq_dmem_we   = 1'b0;
      seq_dmem_addr = DMEM_AW'(cnt_q);
      rd_issue      = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_go) begin
               state_d   = LOAD;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         LOAD: begin
            if (prog_valid && prog_ready_q) begin
               seq_imem_we = 1'b1;
               if (cnt_q == CW'(IMEM_WORDS - 1)) begin
                  state_d = CLEAR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         CLEAR: begin
            seq_dmem_we = 1'b1;
            if (cnt_q == CW'(DMEM_WORDS - 1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            // First RUN cycle still sees ap_done from the core's reset PC.
            if (cnt_q != '0 && core_done) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d   = DRAIN;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DRAIN: begin
            if (rd_idle) rd_issue = 1'b1;
            if (rd_fire) begin
               if (cnt_q == CW'(DMEM_WORDS - 1)) begin
                  state_d    = IDLE;
                  cnt_d      = '0;
                  job_done_d = 1'b1;
               end else begin
                  // Issue the next read in the handshake cycle to sustain 2 cycles/word.
                  cnt_d         = cnt_q + CW'(1);
                  rd_issue      = 1'b1;
                  seq_dmem_addr = DMEM_AW'(cnt_q + CW'(1));
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      prog_ready_d = (state_d == LOAD);
      busy_d       = (state_d != IDLE);
      core_start_d = (state_d != RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         prog_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         core_start_q <= 1'b1;
         job_done_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         prog_ready_q <= prog_ready_d;
         busy_q       <= busy_d;
         core_start_q <= core_start_d;
         job_done_q   <= job_done_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      run = (state_q == RUN);
      imem_addr = run ? core_imem_addr : IMEM_AW'(cnt_q);
      imem_we   = run ? 1'b0 : seq_imem_we;
      imem_d    = prog_data;
      dmem_addr = run ? core_dmem_addr : seq_dmem_addr;
      dmem_we   = run ? core_dmem_we : seq_dmem_we;
      dmem_d    = run ? core_dmem_d : '0;
   end

   assign prog_ready  = prog_ready_q;
   assign busy        = busy_q;
   assign core_start  = core_start_q;
   assign job_done    = job_done_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_riscv_kernel_sequencer.sv
// Randomized bench for riscv_kernel_sequencer: BRAM and core behaviour are
// modelled here and the readback is compared with the expected dmem image.
module tb_riscv_kernel_sequencer;

   localparam int IMEM_AW    = 6;
   localparam int DMEM_AW    = 5;
   localparam int DW         = 32;
   localparam int IMEM_WORDS = 40;
   localparam int DMEM_WORDS = 32;
   localparam int TIMEOUT    = 64;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] ADDI_X1  = 32'h05A0_0093;  // addi x1, x0, 0x5A
   localparam logic [31:0] SW_X1    = 32'h0010_2623;  // sw x1, 12(x0)
   localparam logic [31:0] JAL_SELF = 32'h0000_006F;  // jal x0, 0

   logic               clk = 1'b0;
   logic               rst;
   logic               cmd_go;
   logic               prog_valid;
   logic               prog_ready;
   logic [DW-1:0]      prog_data;
   logic               rd_valid;
   logic               rd_ready;
   logic [DW-1:0]      rd_data;
   logic               busy;
   logic               job_done;
   logic               timeout_err;
   logic               core_start;
   logic               core_done;
   logic [IMEM_AW-1:0] core_imem_addr;
   logic [DMEM_AW-1:0] core_dmem_addr;
   logic               core_dmem_we;
   logic [DW-1:0]      core_dmem_d;
   logic [IMEM_AW-1:0] imem_addr;
   logic               imem_we;
   logic [DW-1:0]      imem_d;
   logic [DMEM_AW-1:0] dmem_addr;
   logic               dmem_we;
   logic [DW-1:0]      dmem_d;
   logic [DW-1:0]      dmem_q;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic        last_to  = 1'b0;

   always #5 clk = ~clk;

   riscv_kernel_sequencer #(
      .IMEM_AW    (IMEM_AW),
      .DMEM_AW    (DMEM_AW),
      .DW         (DW),
      .IMEM_WORDS (IMEM_WORDS),
      .DMEM_WORDS (DMEM_WORDS),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_go         (cmd_go),
      .prog_valid     (prog_valid),
      .prog_ready     (prog_ready),
      .prog_data      (prog_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_data        (rd_data),
      .busy           (busy),
      .job_done       (job_done),
      .timeout_err    (timeout_err),
      .core_start     (core_start),
      .core_done      (core_done),
      .core_imem_addr (core_imem_addr),
      .core_dmem_addr (core_dmem_addr),
      .core_dmem_we   (core_dmem_we),
      .core_dmem_d    (core_dmem_d),
      .imem_addr      (imem_addr),
      .imem_we        (imem_we),
      .imem_d         (imem_d),
      .dmem_addr      (dmem_addr),
      .dmem_we        (dmem_we),
      .dmem_d         (dmem_d),
      .dmem_q         (dmem_q)
   );

   // BRAM models plus a log of every imem write address in order.
   logic [DW-1:0] imem_m [1 << IMEM_AW];
   logic [DW-1:0] dmem_m [1 << DMEM_AW];
   int unsigned   imem_wr_log [$];

   always @(posedge clk) begin
      if (imem_we) begin
         imem_m[imem_addr] <= imem_d;
         imem_wr_log.push_back(32'(imem_addr));
      end
      if (dmem_we) dmem_m[dmem_addr] <= dmem_d;
      dmem_q <= dmem_m[dmem_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // mode 0: nop/sw program, 1: random, 2: never-done loop, 3: reset in RUN, 4: drain stall
   task automatic run_job(input int mode);
      logic [DW-1:0]      prog    [IMEM_WORDS];
      logic [DW-1:0]      exp_mem [DMEM_WORDS];
      logic [DMEM_AW-1:0] w_addr  [$];
      logic [DW-1:0]      w_data  [$];
      logic [DW-1:0]      got     [$];
      int unsigned        base, d, nw, k, exp_len, jd, stall_left;
      logic               exp_to, ok, aborted, stalled, prev_stall;
      logic [DW-1:0]      prev_data;

      for (int w = 0; w < IMEM_WORDS; w++) begin
         case (mode)
            0:       prog[w] = (w == IMEM_WORDS - 2) ? ADDI_X1 :
                               (w == IMEM_WORDS - 1) ? SW_X1 : NOP;
            2:       prog[w] = JAL_SELF;
            default: prog[w] = $urandom;
         endcase
      end
      for (int i = 0; i < DMEM_WORDS; i++) exp_mem[i] = '0;
      if (mode == 0) begin
         nw = 1;
         w_addr.push_back(DMEM_AW'(3));
         w_data.push_back(32'h0000_005A);
         d = 3;
      end else begin
         nw = $urandom_range(1, 6);
         for (int i = 0; i < int'(nw); i++) begin
            w_addr.push_back(DMEM_AW'($urandom_range(0, DMEM_WORDS - 1)));
            w_data.push_back($urandom);
         end
         d = (mode == 2 || mode == 3) ? 100000 : nw + $urandom_range(1, 40);
      end
      for (int i = 0; i < int'(nw); i++) exp_mem[w_addr[i]] = w_data[i];
      exp_to  = (d > TIMEOUT - 1);
      exp_len = exp_to ? TIMEOUT : d + 1;

      check_eq("to_sticky_idle", 32'(timeout_err), 32'(last_to));
      base      = imem_wr_log.size();
      core_done = 1'b1;  // stale ap_done from a core held in reset
      cmd_go    = 1'b1;
      @(negedge clk);
      cmd_go = 1'b0;
      check_eq("start_busy", 32'(busy), 1);
      check_eq("start_to_clr", 32'(timeout_err), 0);
      check_eq("start_core_held", 32'(core_start), 1);

      for (int w = 0; w < IMEM_WORDS; w++) begin
         int unsigned gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < int'(gap); g++) begin
            prog_valid = 1'b0;
            @(negedge clk);
         end
         prog_valid = 1'b1;
         prog_data  = prog[w];
         if (mode == 0 && w == 10) cmd_go = 1'b1;
         ok = 1'b0;
         for (int t = 0; t < 8 && !ok; t++) begin
            ok = prog_ready;
            @(negedge clk);
            cmd_go = 1'b0;
         end
         if (!ok) check_eq("load_ready", 32'(prog_ready), 1);
      end
      prog_valid = 1'b0;

      check_eq("imem_wr_count", 32'(imem_wr_log.size() - base), IMEM_WORDS);
      for (int i = 0; i < IMEM_WORDS; i++) begin
         if (base + i < imem_wr_log.size())
            check_eq("imem_wr_addr", imem_wr_log[base + i], 32'(i));
         check_eq("imem_word", imem_m[i], prog[i]);
      end

      ok = 1'b0;
      for (int t = 0; t < 3 * DMEM_WORDS && !ok; t++) begin
         if (!core_start) ok = 1'b1;
         else @(negedge clk);
      end
      check_eq("run_entered", 32'(core_start), 0);

      k = 0;
      aborted = 1'b0;
      while (!core_start && k < 4 * TIMEOUT) begin
         core_done      = (k == 0) ? 1'b1 : (k == d);
         core_imem_addr = IMEM_AW'($urandom_range(0, (1 << IMEM_AW) - 1));
         core_dmem_we   = (k >= 1 && k <= nw);
         if (k >= 1 && k <= nw) begin
            core_dmem_addr = w_addr[k - 1];
            core_dmem_d    = w_data[k - 1];
         end
         if (k == 2) begin
            #1;
            check_eq("run_imem_mux", 32'(imem_addr), 32'(core_imem_addr));
            check_eq("run_imem_we", 32'(imem_we), 0);
            check_eq("run_dmem_mux", 32'(dmem_addr), 32'(core_dmem_addr));
         end
         if (mode == 3 && k == 5) begin
            rst          = 1'b1;
            core_dmem_we = 1'b1;
            @(negedge clk);
            check_eq("rst_busy", 32'(busy), 0);
            check_eq("rst_core_start", 32'(core_start), 1);
            check_eq("rst_imem_we", 32'(imem_we), 0);
            check_eq("rst_dmem_we", 32'(dmem_we), 0);
            check_eq("rst_prog_ready", 32'(prog_ready), 0);
            check_eq("rst_rd_valid", 32'(rd_valid), 0);
            rst          = 1'b0;
            core_dmem_we = 1'b0;
            core_done    = 1'b0;
            last_to      = 1'b0;
            aborted      = 1'b1;
            break;
         end
         @(negedge clk);
         k++;
      end
      core_dmem_we = 1'b0;
      core_done    = 1'b0;
      if (aborted) return;

      check_eq("run_len", k, exp_len);
      check_eq("timeout_err", 32'(timeout_err), 32'(exp_to));
      last_to = exp_to;

      jd = 0;
      stalled = 1'b0;
      stall_left = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int c = 0; c < 8 * DMEM_WORDS && got.size() < DMEM_WORDS; c++) begin
         if (prev_stall) begin
            check_eq("hold_valid", 32'(rd_valid), 1);
            check_eq("hold_data", rd_data, prev_data);
         end
         if (job_done) jd++;
         if (mode == 4 && !stalled && got.size() == 12) begin
            stalled    = 1'b1;
            stall_left = 10;
         end
         if (stall_left > 0) begin
            rd_ready = 1'b0;
            stall_left--;
         end else begin
            rd_ready = (mode == 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
         if (rd_valid && rd_ready) got.push_back(rd_data);
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
         @(negedge clk);
      end
      rd_ready = 1'b0;
      check_eq("drain_count", 32'(got.size()), DMEM_WORDS);
      check_eq("early_job_done", jd, 0);
      check_eq("job_done_pulse", 32'(job_done), 1);
      check_eq("end_busy", 32'(busy), 0);
      check_eq("end_rd_valid", 32'(rd_valid), 0);
      for (int i = 0; i < DMEM_WORDS && i < got.size(); i++)
         check_eq($sformatf("rd_word%0d", i), got[i], exp_mem[i]);
      @(negedge clk);
      check_eq("job_done_single", 32'(job_done), 0);
   endtask

   initial begin
      rst            = 1'b1;
      cmd_go         = 1'b0;
      prog_valid     = 1'b0;
      prog_data      = '0;
      rd_ready       = 1'b0;
      core_done      = 1'b0;
      core_imem_addr = '0;
      core_dmem_addr = '0;
      core_dmem_we   = 1'b0;
      core_dmem_d    = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_prog_ready", 32'(prog_ready), 0);
      check_eq("reset_rd_valid", 32'(rd_valid), 0);
      check_eq("reset_rd_data", rd_data, 0);
      check_eq("reset_busy", 32'(busy), 0);
      check_eq("reset_job_done", 32'(job_done), 0);
      check_eq("reset_timeout", 32'(timeout_err), 0);
      check_eq("reset_core_start", 32'(core_start), 1);
      check_eq("reset_imem_we", 32'(imem_we), 0);
      check_eq("reset_dmem_we", 32'(dmem_we), 0);
      rst = 1'b0;
      @(negedge clk);

      run_job(0);
      run_job(1);
      run_job(1);
      run_job(2);
      run_job(1);
      run_job(4);
      run_job(3);
      run_job(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, expected completion within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
